// File: rtl/fsm_pkg.sv
// Shared types for the protocol FSM and its transition tracker: state encoding,
// transition counter indices and the expected-po lookup.
package fsm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INIT   = 2'd1,
    DECODE = 2'd2
  } fsmstate_e;

  localparam logic [2:0] TR_II      = 3'd0;
  localparam logic [2:0] TR_IN      = 3'd1;
  localparam logic [2:0] TR_ND      = 3'd2;
  localparam logic [2:0] TR_NI      = 3'd3;
  localparam logic [2:0] TR_DD      = 3'd4;
  localparam logic [2:0] TR_DI      = 3'd5;
  localparam logic [2:0] TR_ILLEGAL = 3'd6;
  localparam logic [2:0] TR_POERR   = 3'd7;

  // Encoding 3 never matches a legal pair, so it always lands on TR_ILLEGAL.
  function automatic logic [2:0] tr_classify(input logic [1:0] prev, input logic [1:0] cur);
    case ({prev, cur})
      {IDLE,   IDLE  }: return TR_II;
      {IDLE,   INIT  }: return TR_IN;
      {INIT,   DECODE}: return TR_ND;
      {INIT,   IDLE  }: return TR_NI;
      {DECODE, DECODE}: return TR_DD;
      {DECODE, IDLE  }: return TR_DI;
      default:          return TR_ILLEGAL;
    endcase
  endfunction

  function automatic logic tr_exp_po(input logic [2:0] idx);
    case (idx)
      TR_IN, TR_NI: return 1'b0;
      default:      return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/fsm_sat_counter.sv
// Saturating event counter with synchronous reset and soft clear.
module fsm_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk) begin
    if (reset || clr) count <= '0;
    else if (inc)     count <= sat_inc(count);
  end

endmodule

// File: rtl/fsm_trans_tracker.sv
// Counts FSM state transitions, flags illegal ones and offers a registered readout.
// Optional po-vs-transition check enabled by defining FSM_TRACK_PO_CHECK_EN.
module fsm_trans_tracker
  import fsm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [1:0]       state_in,
  input  logic             po_in,
  input  logic             clr,
  input  logic [2:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             armed,
  output logic             illegal_seen,
  output logic [3:0]       last_illegal,
  output logic             po_err
);

  typedef enum logic {EMPTY, ARMED} trk_state_e;

  trk_state_e       state_q, state_d;
  logic [1:0]       prev_state_q;
  logic             hit;
  logic             ill_hit;
  logic             po_mis;
  logic [2:0]       tr_idx;
  logic [7:0]       inc;
  logic [CNT_W-1:0] cnt [8];

  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // A clear wipes history, so a coincident sample only re-arms the tracker.
  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    if (clr) begin
      state_d = valid_in ? ARMED : EMPTY;
    end else if (valid_in) begin
      state_d = ARMED;
      hit     = (state_q == ARMED);
    end
  end

  assign armed   = (state_q == ARMED);
  assign tr_idx  = tr_classify(prev_state_q, state_in);
  assign ill_hit = hit && (tr_idx == TR_ILLEGAL);

`ifdef FSM_TRACK_PO_CHECK_EN
  assign po_mis = hit && (tr_idx != TR_ILLEGAL) && (po_in != tr_exp_po(tr_idx));

  always_ff @(posedge clk) begin
    if (reset || clr) po_err <= 1'b0;
    else if (po_mis)  po_err <= 1'b1;
  end
`else
  logic unused_po;
  assign unused_po = po_in;
  assign po_mis    = 1'b0;
  assign po_err    = 1'b0;
`endif

  always_comb begin
    inc = '0;
    if (hit) inc[tr_idx] = 1'b1;
    inc[TR_POERR] = po_mis;
  end

  always_ff @(posedge clk) begin
    if (reset)         prev_state_q <= IDLE;
    else if (valid_in) prev_state_q <= state_in;
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      illegal_seen <= 1'b0;
      last_illegal <= '0;
    end else if (ill_hit) begin
      illegal_seen <= 1'b1;
      last_illegal <= {prev_state_q, state_in};
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_cnt
    fsm_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .inc   (inc[i]),
      .count (cnt[i])
    );
  end

  // Readout stage: one register after the counters.
  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= cnt[rd_sel];
  end

endmodule

// File: doc/fsm_trans_tracker.md
# fsm_trans_tracker

Downstream companion of the protocol FSM: samples the FSM's registered `state` and `po` outputs every valid cycle, counts each legal state transition in saturating counters, flags illegal transitions, and (optionally) checks that `po` matches the transition taken. It sits on the FSM's output side in the same clock domain and provides a registered readout port for the bench's scoreboard and coverage collector.

## Interface
- `CNT_W`, 16: width of every transition/error counter (min 4).
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `valid_in`  in  1  `state_in`/`po_in` hold a fresh FSM sample this cycle.
- `state_in`  in  2  FSM state (`fsmstate_e`: IDLE=0, INIT=1, DECODE=2; 3 is unused).
- `po_in`  in  1  FSM output `po` produced with `state_in`.
- `clr`  in  1  synchronous soft clear of counters and flags.
- `rd_sel`  in  3  readout select.
- `rd_data`  out  CNT_W  registered counter value selected by previous-cycle `rd_sel`.
- `armed`  out  1  a previous state is held; the next sample forms a transition.
- `illegal_seen`  out  1  sticky; set on the first illegal transition.
- `last_illegal`  out  4  {prev, cur} of the most recent illegal transition.
- `po_err`  out  1  sticky po-mismatch flag (tied 0 when the check is compiled out).

## Operation
- Tracker states: EMPTY (no previous sample) and ARMED (prev_state valid).
- EMPTY + `valid_in`: load prev_state←`state_in`, go to ARMED, count nothing.
- ARMED + `valid_in`: classify (prev_state→`state_in`), bump the matching counter, then prev_state←`state_in`.
- Legal transitions and their counter index (rd_sel), with expected `po`: 0 IDLE→IDLE po=1; 1 IDLE→INIT po=0; 2 INIT→DECODE po=1; 3 INIT→IDLE po=0; 4 DECODE→DECODE po=1; 5 DECODE→IDLE po=1.
- Illegal transitions are IDLE→DECODE, INIT→INIT, DECODE→INIT, and any transition where either end is 3. Each one increments the illegal counter (rd_sel 6), sets `illegal_seen`, and loads `last_illegal`. prev_state still updates to `state_in`.
- rd_sel 7 reads the po-mismatch counter.
- Counters saturate at 2^CNT_W−1 and never wrap.
- `valid_in`=0: no state change; prev_state is held across gaps.

## Timing
- Reset values: all counters 0, `rd_data`=0, `armed`=0, `illegal_seen`=0, `last_illegal`=0, `po_err`=0; tracker goes to EMPTY.
- A counter or flag update is visible one cycle after the sampling edge. `rd_data` adds one more register stage: a sample at edge N is readable at `rd_data` after edge N+2.
- `clr` clears counters and flags and forces EMPTY. If `valid_in` is high in the same cycle, that sample is loaded as the new prev_state (tracker ends ARMED) and no transition is counted.
- `reset` overrides `clr` and `valid_in`. Reset mid-stream discards prev_state, so the first post-reset sample is never counted.
- A counter at saturation with a new hit stays at max. Other counters are unaffected.

## Configuration
- `FSM_TRACK_PO_CHECK_EN` defined:
  - On every ARMED legal transition, compare `po_in` with the expected `po` from the table above.
  - On a mismatch, increment counter 7 and set `po_err` (sticky until reset or `clr`).
  - Illegal transitions are not po-checked.
- Not defined: no compare logic; `po_err`=0 and rd_sel 7 reads 0.

## Structure
- Shared package `fsm_pkg`:
  - `fsmstate_e`, shared with the FSM.
  - Index constants TR_II…TR_DI (0–5), TR_ILLEGAL=6, TR_POERR=7.
  - Expected-po lookup function.
- Sub-module `fsm_sat_counter`, parameterised by CNT_W, with inc/clr inputs. Eight instances.

## Test plan
- Reset, then samples IDLE,INIT,DECODE,DECODE,IDLE with correct po → counters 1,2,4,5 = 1 and counter 4 = 1; `illegal_seen`=0; `rd_data` for rd_sel 2 reads 1 two cycles after that sample.
- Samples IDLE then DECODE → counter 6 = 1, `illegal_seen`=1, `last_illegal`=4'b0010. A following DECODE→IDLE is still counted (counter 5 = 1).
- CNT_W=4, 20 IDLE samples → counter 0 = 15 (saturated), other counters 0.
- `clr` asserted together with a valid INIT sample after a DECODE sample → all counters 0, `armed`=1; the next DECODE sample makes counter 2 = 1.
- With `FSM_TRACK_PO_CHECK_EN`: IDLE→INIT with po=1 → counter 7 = 1, `po_err`=1, counter 1 = 1. Without the macro: `po_err`=0 and rd_sel 7 reads 0.
- `reset` pulsed between INIT and DECODE samples → the DECODE sample is not counted, `armed`=1 after it, all counters 0.
